router_fsm: RTL and testbench
=============================

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 resetn  input  1  synchronous active-high reset (1 = reset, despite the name).
REQ-005 packet_valid  input  1  header/payload byte present on the data bus.
REQ-006 datain  input  2  destination address (header bits [1:0]); 0/1/2 valid, 3 invalid.
REQ-007 fifo_full  input  1  currently addressed output FIFO is full.
REQ-008 fifo_empty_0/1/2  input  1 each  output FIFO n is empty.
REQ-009 soft_reset_0/1/2  input  1 each  output FIFO n timed out (abort request).
REQ-010 parity_done  input  1  parity byte already stored by the register block.
REQ-011 low_packet_valid  input  1  packet_valid fell while the FIFO was full.
REQ-012 Outputs, all 1 bit: write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state, rst_int_reg, busy.

Function
REQ-013 The block SHALL be a Moore FSM with 8 states:
- DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), LOAD_PARITY (LP)
- FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), WAIT_TILL_EMPTY (WTE), CHECK_PARITY_ERROR (CPE)
REQ-014 A 2-bit address register SHALL capture datain on every clock while in DA with packet_valid=1; it holds otherwise and resets to 0.
REQ-015 DA transitions; datain=3 with packet_valid=1 SHALL stay in DA:
- packet_valid=1, datain=n (n<3), fifo_empty_n=1 -> LFD
- packet_valid=1, datain=n (n<3), fifo_empty_n=0 -> WTE
- otherwise -> stay in DA
REQ-016 LFD SHALL go to LD unconditionally.
REQ-017 LD transitions:
- fifo_full=1 -> FFS (takes priority)
- else packet_valid=0 -> LP
- else stay in LD
REQ-018 LP SHALL go to CPE unconditionally.
REQ-019 CPE transitions: fifo_full=1 -> FFS; else -> DA.
REQ-020 FFS transitions: fifo_full=0 -> LAF; else stay in FFS.
REQ-021 LAF transitions:
- parity_done=1 -> DA
- parity_done=0, low_packet_valid=1 -> LP
- parity_done=0, low_packet_valid=0 -> LD
REQ-022 WTE transitions: fifo_empty of the latched address = 1 -> LFD; else stay in WTE.
REQ-023 Soft reset SHALL abort to DA on the next edge when soft_reset_n=1 and n equals the latched address. This applies from any state and overrides every other transition except resetn. soft_reset of a non-addressed port SHALL be ignored.
REQ-024 Output decode, combinational from the current state only:
- detect_add = DA
- lfd_state = LFD
- ld_state = LD
- laf_state = LAF
- full_state = FFS
- rst_int_reg = CPE
- write_enb_reg = LD | LP | LAF
- busy = LFD | LP | FFS | LAF | WTE | CPE (busy=0 in DA and LD)
REQ-025 Exactly one of detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg SHALL be 1 in DA, LFD, LD, LAF, FFS and CPE; in LP and WTE all six SHALL be 0.

Reset
REQ-026 With resetn=1 at a clock edge, the state SHALL become DA and the address register 0. Resulting outputs: detect_add=1, all other outputs 0.
REQ-027 Reset SHALL take priority over soft reset and all transitions, including when asserted mid-packet.

Configuration
REQ-028 With macro ROUTER_FSM_SOFT_RESET_EN defined, REQ-023 is implemented. Without it, soft_reset_0/1/2 are ignored, with no other functional change.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- resetn=1 for 1 cycle -> detect_add=1, busy=0, write_enb_reg=0.
- In DA: packet_valid=1, datain=1, fifo_empty_1=1 -> lfd_state=1 and busy=1 for one cycle, then ld_state=1 and write_enb_reg=1. Then packet_valid=0 -> LP (write_enb_reg=1, busy=1), then rst_int_reg=1, then detect_add=1.
- In DA: packet_valid=1, datain=0, fifo_empty_0=0 -> WTE (busy=1, detect_add=0). Then fifo_empty_0=1 -> lfd_state=1.
- In LD: fifo_full=1 -> full_state=1, busy=1. Then fifo_full=0 -> laf_state=1. Then parity_done=0, low_packet_valid=1 -> LP.
- In LD for address 2: soft_reset_1=1 -> no change; soft_reset_2=1 -> detect_add=1 next cycle (macro defined), no change (macro undefined).
- In DA: packet_valid=1, datain=3 -> stays in DA, detect_add=1.

Source files
------------

// File: rtl/router_fsm.sv
// Router control FSM (Moore). Sequences a packet from header decode through payload, parity
// and FIFO-full handling for one of three output FIFOs.
//
// Optional feature: define ROUTER_FSM_SOFT_RESET_EN to let soft_reset_<n> of the latched
// output port abort the current packet back to address decode. Without the macro the
// soft_reset_<n> inputs are ignored.
//
// Ports:
//   clk                   sole clock, rising edge
//   resetn                synchronous reset, active HIGH (1 = reset, despite the name)
//   packet_valid          header/payload byte present
//   datain[1:0]           destination address from header; 3 is invalid
//   fifo_full             addressed output FIFO is full
//   fifo_empty_0/1/2      output FIFO n is empty
//   soft_reset_0/1/2      output FIFO n timed out
//   parity_done           parity byte already stored
//   low_packet_valid      packet_valid fell while FIFO was full
//   write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state, rst_int_reg, busy
//                         state decode outputs
module router_fsm (
  input  logic       clk,
  input  logic       resetn,
  input  logic       packet_valid,
  input  logic [1:0] datain,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       lfd_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    StDa, StLfd, StLd, StLp, StFfs, StLaf, StWte, StCpe
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       addr_empty;
  logic       addr_soft_reset;

  // Empty flag of the FIFO selected by the latched address.
  always_comb begin
    addr_empty = 1'b0;
    case (addr_q)
      2'd0:    addr_empty = fifo_empty_0;
      2'd1:    addr_empty = fifo_empty_1;
      2'd2:    addr_empty = fifo_empty_2;
      default: addr_empty = 1'b0;
    endcase
  end

`ifdef ROUTER_FSM_SOFT_RESET_EN
  always_comb begin
    addr_soft_reset = 1'b0;
    case (addr_q)
      2'd0:    addr_soft_reset = soft_reset_0;
      2'd1:    addr_soft_reset = soft_reset_1;
      2'd2:    addr_soft_reset = soft_reset_2;
      default: addr_soft_reset = 1'b0;
    endcase
  end
`else
  logic unused_soft_reset;
  assign unused_soft_reset = soft_reset_0 ^ soft_reset_1 ^ soft_reset_2;
  assign addr_soft_reset   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == StDa && packet_valid) begin
      addr_d = datain;
    end
    unique case (state_q)
      StDa: begin
        // In DA the decision uses the live header address, not the latched one.
        if (packet_valid && datain != 2'd3) begin
          case (datain)
            2'd0:    state_d = fifo_empty_0 ? StLfd : StWte;
            2'd1:    state_d = fifo_empty_1 ? StLfd : StWte;
            default: state_d = fifo_empty_2 ? StLfd : StWte;
          endcase
        end
      end
      StLfd: state_d = StLd;
      StLd: begin
        if (fifo_full)          state_d = StFfs;
        else if (!packet_valid) state_d = StLp;
      end
      StLp:  state_d = StCpe;
      StCpe: state_d = fifo_full ? StFfs : StDa;
      StFfs: if (!fifo_full) state_d = StLaf;
      StLaf: begin
        if (parity_done)           state_d = StDa;
        else if (low_packet_valid) state_d = StLp;
        else                       state_d = StLd;
      end
      StWte: if (addr_empty) state_d = StLfd;
      default: state_d = StDa;
    endcase
    if (addr_soft_reset) begin
      state_d = StDa;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= StDa;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign detect_add    = (state_q == StDa);
  assign lfd_state     = (state_q == StLfd);
  assign ld_state      = (state_q == StLd);
  assign laf_state     = (state_q == StLaf);
  assign full_state    = (state_q == StFfs);
  assign rst_int_reg   = (state_q == StCpe);
  assign write_enb_reg = (state_q == StLd) || (state_q == StLp) || (state_q == StLaf);
  assign busy          = !((state_q == StDa) || (state_q == StLd));

endmodule

// File: tb/tb_router_fsm.sv
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       packet_valid = 1'b0;
  logic [1:0] datain = 2'd0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_packet_valid = 1'b0;
  logic       write_enb_reg, detect_add, ld_state, laf_state;
  logic       lfd_state, full_state, rst_int_reg, busy;

  router_fsm dut (
    .clk              (clk),
    .resetn           (resetn),
    .packet_valid     (packet_valid),
    .datain           (datain),
    .fifo_full        (fifo_full),
    .fifo_empty_0     (fifo_empty_0),
    .fifo_empty_1     (fifo_empty_1),
    .fifo_empty_2     (fifo_empty_2),
    .soft_reset_0     (soft_reset_0),
    .soft_reset_1     (soft_reset_1),
    .soft_reset_2     (soft_reset_2),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .write_enb_reg    (write_enb_reg),
    .detect_add       (detect_add),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .lfd_state        (lfd_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Reference model: phases of a packet's life, numbered independently of the design.
  localparam int DA = 0, LFD = 1, LD = 2, LP = 3, FFS = 4, LAF = 5, WTE = 6, CPE = 7;

  int model_state = DA;
  int model_addr  = 0;
  int total = 0;
  int bad   = 0;
  int cycle = 0;

  typedef struct {
    logic [7:0] outs;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  // Output vector {write_enb_reg, detect_add, ld, laf, lfd, full, rst_int_reg, busy}.
  function automatic logic [7:0] expect_outs(input int s);
    case (s)
      DA:      return 8'b0100_0000;
      LFD:     return 8'b0000_1001;
      LD:      return 8'b1010_0000;
      LP:      return 8'b1000_0001;
      FFS:     return 8'b0000_0101;
      LAF:     return 8'b1001_0001;
      WTE:     return 8'b0000_0001;
      default: return 8'b0000_0011;
    endcase
  endfunction

  task automatic step(input logic rst = 1'b0, input logic pv = 1'b0,
                      input logic [1:0] d = 2'd0, input logic full = 1'b0,
                      input logic e0 = 1'b1, input logic e1 = 1'b1, input logic e2 = 1'b1,
                      input logic s0 = 1'b0, input logic s1 = 1'b0, input logic s2 = 1'b0,
                      input logic pd = 1'b0, input logic lpv = 1'b0);
    logic [2:0] emp;
    logic [2:0] sr;
    int         nxt;
    @(negedge clk);
    resetn = rst; packet_valid = pv; datain = d; fifo_full = full;
    fifo_empty_0 = e0; fifo_empty_1 = e1; fifo_empty_2 = e2;
    soft_reset_0 = s0; soft_reset_1 = s1; soft_reset_2 = s2;
    parity_done = pd; low_packet_valid = lpv;
    emp = {e2, e1, e0};
    sr  = {s2, s1, s0};
    nxt = model_state;
    case (model_state)
      DA:  if (pv && d != 2'd3) nxt = emp[d] ? LFD : WTE;
      LFD: nxt = LD;
      LD:  nxt = full ? FFS : (!pv ? LP : LD);
      LP:  nxt = CPE;
      CPE: nxt = full ? FFS : DA;
      FFS: nxt = full ? FFS : LAF;
      LAF: nxt = pd ? DA : (lpv ? LP : LD);
      WTE: if (model_addr < 3 && emp[model_addr]) nxt = LFD;
      default: nxt = DA;
    endcase
`ifdef ROUTER_FSM_SOFT_RESET_EN
    if (model_addr < 3 && sr[model_addr]) nxt = DA;
`else
    if (sr != 3'b000) nxt = nxt;
`endif
    if (model_state == DA && pv) model_addr = int'(d);
    model_state = nxt;
    if (rst) begin
      model_state = DA;
      model_addr  = 0;
    end
    cycle++;
    exp_q.push_back('{outs: expect_outs(model_state), cyc: cycle});
  endtask

  // Monitor: every edge the DUT presents a state decode; compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = {write_enb_reg, detect_add, ld_state, laf_state,
             lfd_state, full_state, rst_int_reg, busy};
      total++;
      if (act !== e.outs) begin
        bad++;
        $display("FAIL outputs cycle %0d: got %b want %b (web,det,ld,laf,lfd,full,rst,busy)",
                 e.cyc, act, e.outs);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then idle.
    step(.rst(1'b1));
    step();
    // Header to port 1 with FIFO empty: LFD, LD, LP, CPE, DA.
    step(.pv(1'b1), .d(2'd1));
    step(.pv(1'b1));
    step(.pv(1'b0));
    step();
    step();
    // Header to port 0 while FIFO 0 not empty: WTE until it empties.
    step(.pv(1'b1), .d(2'd0), .e0(1'b0));
    step(.e0(1'b0));
    step(.e0(1'b1));
    step(.pv(1'b1));
    // In LD: full, released, then LAF with low_packet_valid -> LP -> CPE -> DA.
    step(.pv(1'b1), .full(1'b1));
    step(.pv(1'b1), .full(1'b1));
    step(.pv(1'b1));
    step(.pd(1'b0), .lpv(1'b1));
    step();
    step();
    // LAF with parity_done back to DA, and plain LAF -> LD.
    step(.pv(1'b1), .d(2'd2));
    step(.pv(1'b1));
    step(.pv(1'b1), .full(1'b1));
    step(.pv(1'b1));
    step(.pv(1'b1));
    step(.pv(1'b1), .full(1'b1));
    step(.pv(1'b1));
    step(.pd(1'b1));
    // Port 2 in LD: foreign soft reset ignored, own soft reset aborts when enabled.
    step(.pv(1'b1), .d(2'd2));
    step(.pv(1'b1));
    step(.pv(1'b1), .s1(1'b1));
    step(.pv(1'b1), .s2(1'b1));
    step(.rst(1'b1));
    // Invalid address stays in DA.
    step(.pv(1'b1), .d(2'd3));
    step(.pv(1'b1), .d(2'd3));
    // Reset mid-packet.
    step(.pv(1'b1), .d(2'd0));
    step(.pv(1'b1));
    step(.pv(1'b1), .rst(1'b1));
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(.rst($urandom_range(0, 63) == 0),
           .pv($urandom_range(0, 3) != 0),
           .d(2'($urandom_range(0, 3))),
           .full($urandom_range(0, 3) == 0),
           .e0($urandom_range(0, 2) != 0),
           .e1($urandom_range(0, 2) != 0),
           .e2($urandom_range(0, 2) != 0),
           .s0($urandom_range(0, 15) == 0),
           .s1($urandom_range(0, 15) == 0),
           .s2($urandom_range(0, 15) == 0),
           .pd($urandom_range(0, 2) == 0),
           .lpv($urandom_range(0, 1) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
